// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the device clock, frames
// 11-bit words and turns scan-code sequences into single-cycle make-code strobes.
module ps2_keycode_receiver #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyCode,
   output logic       keyValid,
   output logic       keyExtended,
   output logic       frameError
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   localparam logic [7:0] B_EXT = 8'hE0;
   localparam logic [7:0] B_BRK = 8'hF0;

   logic          clk_s1_q, clk_s2_q;
   logic          dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic          fprev_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall;

   logic [1:0]    state_q, state_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] to_q, to_d;
   logic          chk_ok, chk_bad, tmo;

   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          kext_q, kext_d;
   logic          ferr_q, ferr_d;
   logic [7:0]    rx_byte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Any sample agreeing with the current level restarts the run count.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q  <= 1'b1;
         fprev_q <= 1'b1;
         fcnt_q  <= '0;
      end else begin
         filt_q  <= filt_d;
         fprev_q <= filt_q;
         fcnt_q  <= fcnt_d;
      end
   end

   assign fall = fprev_q & ~filt_q;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      to_d    = to_q;
      chk_ok  = 1'b0;
      chk_bad = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            to_d  = '0;
            bit_d = '0;
            if (fall && !dat_s2_q) begin
               state_d = S_RECV;
               bit_d   = 4'd1;
            end
         end
         S_RECV: begin
            if (fall) begin
               shift_d = {dat_s2_q, shift_q[9:1]};
               to_d    = '0;
               if (bit_q == 4'd10) begin
                  state_d = S_CHECK;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo     = 1'b1;
               state_d = S_IDLE;
               bit_d   = '0;
               to_d    = '0;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            // shift_q: [7:0] data, [8] odd parity, [9] stop
            if ((^shift_q[8:0]) && shift_q[9]) begin
               chk_ok = 1'b1;
            end else begin
               chk_bad = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            bit_d   = '0;
            to_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         to_q    <= to_d;
      end
   end

   assign rx_byte = shift_q[7:0];

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      code_d  = 8'h00;
      valid_d = 1'b0;
      kext_d  = 1'b0;
      ferr_d  = chk_bad | tmo;
      if (chk_bad || tmo) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (chk_ok) begin
         if (rx_byte == B_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == B_BRK) begin
            brk_d = 1'b1;
         end else begin
            // Break codes are swallowed; only make codes reach the output.
            if (!brk_q) begin
               code_d  = rx_byte;
               valid_d = 1'b1;
               kext_d  = ext_q;
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         code_q  <= 8'h00;
         valid_q <= 1'b0;
         kext_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         kext_q  <= kext_d;
         ferr_q  <= ferr_d;
      end
   end

   assign keyCode     = code_q;
   assign keyValid    = valid_q;
   assign keyExtended = kext_q;
   assign frameError  = ferr_q;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Scoreboard bench for ps2_keycode_receiver: directed PS/2 frames push expected
// events; a negedge monitor pops and compares each keyValid / frameError strobe.
module tb_ps2_keycode_receiver;

   localparam int TMO  = 1000;
   localparam int HALF = 20;

   typedef struct {
      logic       err;
      logic [7:0] code;
      logic       ext;
   } ev_t;

   logic       clk;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keyCode;
   logic       keyValid;
   logic       keyExtended;
   logic       frameError;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   ps2_keycode_receiver #(
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .keyCode(keyCode),
      .keyValid(keyValid),
      .keyExtended(keyExtended),
      .frameError(frameError)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(6);
         ps2_clk = 1'b0;
         wait_cyc(3);
         ps2_clk = 1'b1;
         wait_cyc(HALF - 9);
      end else begin
         wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input int glitch_bit);
      logic par;
      par = ~(^b) ^ bad_par;
      send_bit(1'b0, glitch_bit == 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
      send_bit(par, glitch_bit == 9);
      send_bit(1'b1, glitch_bit == 10);
      ps2_data = 1'b1;
      wait_cyc(40);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, -1);
   endtask

   task automatic exp_key(input logic [7:0] c, input logic e);
      ev_t ev;
      ev.err  = 1'b0;
      ev.code = c;
      ev.ext  = e;
      exp_q.push_back(ev);
   endtask

   task automatic exp_err();
      ev_t ev;
      ev.err  = 1'b1;
      ev.code = 8'h00;
      ev.ext  = 1'b0;
      exp_q.push_back(ev);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_code"}, 32'(keyCode), 32'h0);
      chk({tag, "_valid"}, 32'(keyValid), 32'h0);
      chk({tag, "_ext"}, 32'(keyExtended), 32'h0);
      chk({tag, "_ferr"}, 32'(frameError), 32'h0);
   endtask

   always @(negedge clk) begin
      ev_t ev;
      chk("exclusive", 32'(keyValid & frameError), 32'h0);
      if (!keyValid) begin
         chk("code_idle", 32'(keyCode), 32'h0);
         chk("ext_idle", 32'(keyExtended), 32'h0);
      end
      if (keyValid || frameError) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected: valid=%0b code=%0h err=%0b at %0t",
                     keyValid, keyCode, frameError, $time);
         end else begin
            ev = exp_q.pop_front();
            chk("kind_err", 32'(frameError), 32'(ev.err));
            if (!ev.err) begin
               chk("keycode", 32'(keyCode), 32'(ev.code));
               chk("keyext", 32'(keyExtended), 32'(ev.ext));
            end
         end
      end
   end

   initial begin
      logic [7:0] b;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      chk_outputs_zero("reset");
      reset = 1'b0;
      wait_cyc(20);

      send(8'hE0);
      exp_key(8'h75, 1'b1);
      send(8'h75);

      send(8'hF0);
      send(8'h75);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      exp_key(8'h2B, 1'b0);
      send(8'h2B);

      exp_err();
      send_frame(8'h5A, 1'b1, -1);
      exp_key(8'h5A, 1'b0);
      send(8'h5A);

      exp_err();
      b = 8'h1D;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
      ps2_data = 1'b1;
      wait_cyc(TMO + 200);
      exp_key(8'h1D, 1'b0);
      send(8'h1D);

      exp_key(8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 5);

      b = 8'h74;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_bit(b[i], 1'b0);
      ps2_data = 1'b1;
      reset = 1'b1;
      wait_cyc(3);
      chk_outputs_zero("midreset");
      reset = 1'b0;
      wait_cyc(20);
      exp_key(8'h74, 1'b0);
      send(8'h74);

      exp_key(8'h1C, 1'b0);
      send(8'h1C);
      exp_key(8'h1C, 1'b0);
      send(8'h1C);

      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         wait_cyc(1);
      end
      chk("drain", 32'(exp_q.size()), 32'h0);
      wait_cyc(50);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
